// File: rtl/layer_ddr_writer.sv
// rtl/layer_ddr_writer.sv - drains the conv layer's concat FIFO into DDR as Avalon-MM burst writes
module layer_ddr_writer #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 18816,
    parameter int USEDW_WIDTH = 11
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          frame_start_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic [DATA_WIDTH-1:0]         fifo_q_i,
    input  logic [USEDW_WIDTH-1:0]        fifo_rdusedw_i,
    output logic                          fifo_rd_o,
    output logic [ADDR_WIDTH-1:0]         avm_address_o,
    output logic [$clog2(BURST_LEN):0]    avm_burstcount_o,
    output logic                          avm_write_o,
    output logic [DATA_WIDTH-1:0]         avm_writedata_o,
    output logic [DATA_WIDTH/8-1:0]       avm_byteenable_o,
    input  logic                          avm_waitrequest_i,
    output logic                          busy_o,
    output logic                          frame_done_o,
    output logic                          err_restart_o
);
    localparam int BC_W  = $clog2(BURST_LEN) + 1;
    localparam int FW_W  = $clog2(FRAME_WORDS + 1);
    localparam int WL_W  = (FW_W > BC_W) ? FW_W : BC_W;
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_avm_address;
    logic [WL_W-1:0]       r_words_left;
    logic [BC_W-1:0]       r_burstcount;
    logic [BC_W-1:0]       r_beats_left;
    logic [BC_W-1:0]       r_rd_issued;
    logic                  r_rd_pending;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_head;
    logic [1:0]            r_count;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_err_restart;

    logic [BC_W-1:0] w_blen;
    logic            w_level_ok;
    logic            w_write;
    logic            w_accept;
    logic            w_last_beat;
    logic            w_frame_end;
    logic [2:0]      w_inflight;
    logic            w_rd;
    logic            w_tail;

    always_comb begin
        if (r_words_left >= WL_W'(BURST_LEN)) w_blen = BC_W'(BURST_LEN);
        else                                  w_blen = BC_W'(r_words_left);
    end

    assign w_level_ok  = 32'(fifo_rdusedw_i) >= 32'(w_blen);
    assign w_write     = (r_count != 2'd0);
    assign w_accept    = w_write && !avm_waitrequest_i;
    assign w_last_beat = (r_state == S_BURST) && w_accept && (r_beats_left == BC_W'(1));
    assign w_frame_end = w_last_beat && (r_words_left == WL_W'(r_burstcount));
    assign w_inflight  = {1'b0, r_count} + {2'b00, r_rd_pending};
    // A beat leaving this cycle frees a slot, which keeps back-to-back beats flowing
    assign w_rd        = (r_state == S_BURST) && (r_rd_issued < r_burstcount)
                         && (w_inflight < (w_accept ? 3'd3 : 3'd2));
    assign w_tail      = r_head ^ r_count[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (frame_start_i) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_level_ok) w_state_nxt = S_BURST;
            S_BURST: if (w_last_beat) w_state_nxt = w_frame_end ? S_DONE : S_WAIT;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr        <= '0;
            r_avm_address <= '0;
            r_words_left  <= '0;
            r_burstcount  <= '0;
            r_beats_left  <= '0;
            r_rd_issued   <= '0;
            r_rd_pending  <= 1'b0;
            r_buf[0]      <= '0;
            r_buf[1]      <= '0;
            r_head        <= 1'b0;
            r_count       <= 2'd0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_restart <= 1'b0;
        end else begin
            r_err_restart <= frame_start_i && r_busy;
            r_frame_done  <= w_frame_end;
            r_rd_pending  <= w_rd;
            if (r_state == S_IDLE && frame_start_i) begin
                r_addr       <= base_addr_i;
                r_words_left <= WL_W'(FRAME_WORDS);
                r_busy       <= 1'b1;
            end
            if (r_state == S_DONE) r_busy <= 1'b0;
            if (r_state == S_WAIT && w_level_ok) begin
                r_avm_address <= r_addr;
                r_burstcount  <= w_blen;
                r_beats_left  <= w_blen;
                r_rd_issued   <= '0;
            end
            if (w_rd) r_rd_issued <= r_rd_issued + BC_W'(1);
            if (r_rd_pending) r_buf[w_tail] <= fifo_q_i;
            if (w_accept) begin
                r_head       <= ~r_head;
                r_beats_left <= r_beats_left - BC_W'(1);
            end
            r_count <= r_count + {1'b0, r_rd_pending} - {1'b0, w_accept};
            if (w_last_beat) begin
                r_addr       <= r_addr + ADDR_WIDTH'(r_burstcount) * ADDR_WIDTH'(BYTES);
                r_words_left <= r_words_left - WL_W'(r_burstcount);
            end
        end
    end

    assign fifo_rd_o        = w_rd;
    assign avm_address_o    = r_avm_address;
    assign avm_burstcount_o = r_burstcount;
    assign avm_write_o      = w_write;
    assign avm_writedata_o  = r_buf[r_head];
    assign avm_byteenable_o = {BYTES{w_write}};
    assign busy_o           = r_busy;
    assign frame_done_o     = r_frame_done;
    assign err_restart_o    = r_err_restart;
endmodule

// File: tb/tb_layer_ddr_writer.sv
// tb/tb_layer_ddr_writer.sv - randomized bench for layer_ddr_writer against a transaction-level model
module tb_layer_ddr_writer;
    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int BL  = 16;
    localparam int FW  = 36;
    localparam int UW  = 11;
    localparam int BCW = $clog2(BL) + 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            frame_start_i = 1'b0;
    logic [AW-1:0]   base_addr_i = '0;
    logic [DW-1:0]   fifo_q_i = '0;
    logic [UW-1:0]   fifo_rdusedw_i = '0;
    logic            fifo_rd_o;
    logic [AW-1:0]   avm_address_o;
    logic [BCW-1:0]  avm_burstcount_o;
    logic            avm_write_o;
    logic [DW-1:0]   avm_writedata_o;
    logic [DW/8-1:0] avm_byteenable_o;
    logic            avm_waitrequest_i = 1'b0;
    logic            busy_o;
    logic            frame_done_o;
    logic            err_restart_o;

    layer_ddr_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL),
                       .FRAME_WORDS(FW), .USEDW_WIDTH(UW)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start_i(frame_start_i),
        .base_addr_i(base_addr_i), .fifo_q_i(fifo_q_i), .fifo_rdusedw_i(fifo_rdusedw_i),
        .fifo_rd_o(fifo_rd_o), .avm_address_o(avm_address_o),
        .avm_burstcount_o(avm_burstcount_o), .avm_write_o(avm_write_o),
        .avm_writedata_o(avm_writedata_o), .avm_byteenable_o(avm_byteenable_o),
        .avm_waitrequest_i(avm_waitrequest_i), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .err_restart_o(err_restart_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    logic [DW-1:0] fifo[$];
    logic [DW-1:0] exp_data[$];
    logic [DW-1:0] drv_w;
    int            wr_pct = 0;
    logic          rd_seen = 1'b0;

    int            mcyc = 0;
    logic          m_busy = 1'b0;
    logic          m_active = 1'b0;
    logic [AW-1:0] m_base = '0;
    int            m_beats = 0;
    int            m_reads = 0;
    int            m_done_cyc = -1;
    int            m_err_cyc = -1;
    int            m_start_cyc = 0;
    int            acc_cyc[64];
    logic [AW-1:0] rec_addr[8];
    logic [BCW-1:0] rec_bc[8];
    int            n_done_pulses = 0;
    int            n_err_pulses = 0;
    int            n_wr = 0;
    int            n_rd = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO with 1-cycle read latency; inputs change 1 time unit after the clock edge
    always @(posedge clk) begin
        #1;
        if (rd_seen && reset_n && fifo.size() > 0) begin
            drv_w = fifo.pop_front();
            fifo_q_i = drv_w;
            exp_data.push_back(drv_w);
        end else begin
            fifo_q_i = {$urandom, $urandom};
        end
        fifo_rdusedw_i = UW'(fifo.size());
        avm_waitrequest_i = (wr_pct != 0) && (int'($urandom_range(99)) < wr_pct);
    end

    always @(negedge clk) begin
        logic          busy_now;
        int            b;
        logic [AW-1:0] ea;
        int            ebc;
        if (!reset_n) begin
            chk("reset_outputs", {fifo_rd_o, avm_write_o, avm_address_o, avm_burstcount_o,
                avm_byteenable_o, busy_o, frame_done_o, err_restart_o}, 64'd0);
            m_busy = 1'b0; m_active = 1'b0; m_beats = 0; m_reads = 0;
            m_done_cyc = -1; m_err_cyc = -1; rd_seen = 1'b0;
        end else begin
            busy_now = m_busy;
            chk("busy_o", busy_o, m_busy);
            chk("frame_done_o", frame_done_o, mcyc == m_done_cyc);
            chk("err_restart_o", err_restart_o, mcyc == m_err_cyc);
            chk("byteenable", avm_byteenable_o, {8{avm_write_o}});
            chk("inflight_le2", (m_reads - m_beats) <= 2, 1);
            if (fifo_rd_o) begin
                chk("rd_in_frame", m_active && (m_reads < FW), 1);
                chk("rd_burst_idx", m_reads / BL, m_beats / BL);
                chk("rd_fifo_nonempty", fifo.size() > 0, 1);
            end
            if (avm_write_o) begin
                chk("write_in_frame", m_active && (m_beats < FW), 1);
                b   = m_beats / BL;
                ea  = m_base + AW'(b * BL * (DW / 8));
                ebc = (FW - b * BL < BL) ? (FW - b * BL) : BL;
                chk("burst_address", avm_address_o, ea);
                chk("burstcount", avm_burstcount_o, ebc);
                if (!avm_waitrequest_i) begin
                    if (exp_data.size() == 0) chk("beat_data_avail", 0, 1);
                    else chk("beat_data", avm_writedata_o, exp_data.pop_front());
                    if ((m_beats % BL) == 0 && b < 8) begin
                        rec_addr[b] = avm_address_o;
                        rec_bc[b]   = avm_burstcount_o;
                    end
                    if (m_beats < 64) acc_cyc[m_beats] = mcyc;
                    m_beats++;
                    if (m_beats == FW) begin
                        m_done_cyc = mcyc + 1;
                        chk("reads_per_frame", m_reads + int'(fifo_rd_o), FW);
                    end
                end
            end
            if (fifo_rd_o) m_reads++;
            if (err_restart_o) n_err_pulses++;
            if (frame_done_o) n_done_pulses++;
            if (avm_write_o) n_wr++;
            if (fifo_rd_o) n_rd++;
            if (mcyc == m_done_cyc) begin
                m_busy = 1'b0;
                m_active = 1'b0;
            end
            if (frame_start_i) begin
                if (busy_now) m_err_cyc = mcyc + 1;
                else begin
                    m_busy = 1'b1; m_active = 1'b1; m_base = base_addr_i;
                    m_beats = 0; m_reads = 0; m_start_cyc = mcyc;
                end
            end
            rd_seen = fifo_rd_o;
        end
        mcyc++;
    end

    task automatic push_words(input int n);
        @(posedge clk);
        #3;
        for (int i = 0; i < n; i++) fifo.push_back({$urandom, $urandom});
    endtask

    task automatic start_frame(input logic [AW-1:0] base);
        @(posedge clk);
        #2;
        frame_start_i = 1'b1;
        base_addr_i   = base;
        @(posedge clk);
        #2;
        frame_start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = n_done_pulses;
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            if (n_done_pulses > d0) break;
        end
        if (i >= budget) chk("wait_done_timeout", 0, 1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int d0, e0, r0, w0, i;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // back-to-back frame, no stalls: latency, throughput, addresses, tail burst
        d0 = n_done_pulses; r0 = n_rd; w0 = n_wr;
        push_words(FW);
        start_frame(32'h1000_0000);
        wait_done(2000);
        chk("t1_first_write_latency", acc_cyc[0] - m_start_cyc, 4);
        chk("t1_burst0_consecutive", acc_cyc[15] - acc_cyc[0], 15);
        chk("t1_burst_gap", acc_cyc[16] - acc_cyc[15], 4);
        chk("t1_tail_consecutive", acc_cyc[35] - acc_cyc[32], 3);
        chk("t1_addr0", rec_addr[0], 32'h1000_0000);
        chk("t1_addr1", rec_addr[1], 32'h1000_0080);
        chk("t1_addr2", rec_addr[2], 32'h1000_0100);
        chk("t1_bc0", rec_bc[0], 16);
        chk("t1_bc2", rec_bc[2], 4);
        chk("t1_done_pulses", n_done_pulses - d0, 1);
        chk("t1_rd_count", n_rd - r0, FW);
        chk("t1_wr_count", n_wr - w0, FW);

        // random stalls, address wrap, restart attempt mid-frame
        d0 = n_done_pulses; e0 = n_err_pulses;
        wr_pct = 50;
        push_words(FW);
        start_frame(32'hFFFF_FF80);
        repeat (20) @(posedge clk);
        start_frame(32'h5555_0000);
        wait_done(4000);
        chk("t2_addr0", rec_addr[0], 32'hFFFF_FF80);
        chk("t2_addr1_wrap", rec_addr[1], 32'h0000_0000);
        chk("t2_addr2_wrap", rec_addr[2], 32'h0000_0080);
        chk("t2_err_pulses", n_err_pulses - e0, 1);
        chk("t2_done_pulses", n_done_pulses - d0, 1);

        // FIFO level one short of a burst holds everything off
        wr_pct = 0; r0 = n_rd;
        push_words(15);
        start_frame(32'h2000_0000);
        d0 = n_wr; w0 = n_rd;
        repeat (100) @(posedge clk);
        chk("t3_no_write_at_15", n_wr - d0, 0);
        chk("t3_no_read_at_15", n_rd - w0, 0);
        push_words(FW - 15);
        wait_done(2000);
        chk("t3_addr0", rec_addr[0], 32'h2000_0000);
        chk("t3_addr2", rec_addr[2], 32'h2000_0100);
        chk("t3_rd_count", n_rd - r0, FW);

        // asynchronous reset after beat 7, then a clean new frame
        wr_pct = 50;
        d0 = n_done_pulses;
        push_words(FW);
        start_frame(32'h3000_0000);
        for (i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (m_beats >= 7) break;
        end
        if (i >= 1000) chk("t4_beat7_timeout", 0, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t4_async_reset_outputs", {fifo_rd_o, avm_write_o, avm_address_o, avm_burstcount_o,
            avm_byteenable_o, busy_o, frame_done_o, err_restart_o}, 64'd0);
        chk("t4_async_reset_data", avm_writedata_o, 64'd0);
        repeat (3) @(posedge clk);
        #3;
        fifo.delete();
        exp_data.delete();
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("t4_no_done_for_aborted", n_done_pulses - d0, 0);
        wr_pct = 25;
        push_words(FW);
        start_frame(32'h4000_0000);
        wait_done(4000);
        chk("t4_addr0", rec_addr[0], 32'h4000_0000);
        chk("t4_addr1", rec_addr[1], 32'h4000_0080);
        chk("t4_done_pulses", n_done_pulses - d0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
